axi_burst_to_lite_conv: RTL
===========================

// Module: axi_burst_to_lite_conv
// PURPOSE
//  AXI4 slave port to AXI4-Lite master port converter with burst splitting and ID reflection in one block.
//  Adds WRAP/FIXED support, reserved-burst/oversize error handling and worst-case B merging.
//  Sits between a crossbar master port and register-file peripherals. Read and write paths are independent.
//  One Lite transaction in flight per direction; any AxiIdWidth.
// PARAMETERS
//  AxiAddrWidth  32  address width, both ports
//  AxiDataWidth  32  data width, both ports (8..1024, power of two)
//  AxiIdWidth    4   slave-side ID width (reflected, never forwarded)
//  SupportWrap   1   1: WRAP bursts converted; 0: WRAP treated as illegal
// PORTS
//  clk_i                                in   1        clock
//  rst_i                                in   1        asynchronous reset, active-high
//  slv_aw_{id,addr,len,size,burst}      in   IdW/AW/8/3/2  AXI4 AW payload
//  slv_aw_valid / slv_aw_ready          in/out 1      AW handshake
//  slv_w_{data,strb,last}, slv_w_valid  in   DW/DW/8/1/1   AXI4 W
//  slv_w_ready                          out  1        W ready
//  slv_b_{id,resp}, slv_b_valid         out  IdW/2/1  AXI4 B
//  slv_b_ready                          in   1        B ready
//  slv_ar_{id,addr,len,size,burst}      in   IdW/AW/8/3/2  AXI4 AR payload
//  slv_ar_valid / slv_ar_ready          in/out 1      AR handshake
//  slv_r_{id,data,resp,last}, slv_r_valid  out IdW/DW/2/1/1  AXI4 R
//  slv_r_ready                          in   1        R ready
//  mst_aw_addr, mst_aw_valid / mst_aw_ready  out,out/in  AW/1/1  Lite AW
//  mst_w_{data,strb}, mst_w_valid / mst_w_ready  out,out/in  DW/DW/8/1/1  Lite W
//  mst_b_resp, mst_b_valid / mst_b_ready     in,in/out   2/1/1  Lite B
//  mst_ar_addr, mst_ar_valid / mst_ar_ready  out,out/in  AW/1/1  Lite AR
//  mst_r_{data,resp}, mst_r_valid / mst_r_ready  in,in/out  DW/2/1/1  Lite R
// BEHAVIOUR
//  Reset (rst_i high, async): both FSMs IDLE, all valids and readies 0, counters 0, stored resp OKAY.
//  Write FSM: IDLE -> BEAT -> WRSP -> (BEAT | BRSP) -> IDLE.
//   IDLE: slv_aw_ready=1; on AW handshake latch id/addr/len/size/burst, beat=0, err=0, resp_acc=OKAY.
//   BEAT: mst_aw_valid and mst_w_valid raised together, each dropped independently once accepted.
//         mst_w_valid = slv_w_valid, slv_w_ready = mst_w_ready (pass-through); leave when both accepted.
//   WRSP: mst_b_ready=1; on B, resp_acc = max(resp_acc, mst_b_resp); if beat==len -> BRSP, else beat++, addr=next.
//   BRSP: slv_b_valid=1, slv_b_id=latched id, slv_b_resp=resp_acc; hold until slv_b_ready.
//  Read FSM: IDLE -> ADDR -> DATA -> (ADDR | IDLE).
//   ADDR: mst_ar_valid=1 until mst_ar_ready. DATA: slv_r_valid=mst_r_valid, mst_r_ready=slv_r_ready,
//   slv_r_{data,resp} pass-through, slv_r_id=latched id, slv_r_last=(beat==len).
//  Address generation (inc = 1<<size):
//   beat 0 uses the AxADDR as given;
//   INCR: next = align(addr,size)+inc, no 4 KiB check;
//   FIXED: next = addr;
//   WRAP: wb=(len+1)*inc, next = (addr & ~(wb-1)) | ((align(addr)+inc) & (wb-1)).
//  Illegal burst: burst==2'b11, size>log2(DW/8), WRAP with SupportWrap=0, or WRAP with len not in {1,3,7,15}.
//   Write: no Lite traffic; slv_w_ready=1 until the W beat with last; then B resp=SLVERR.
//   Read: no Lite traffic; len+1 R beats, data 0, resp SLVERR, last on the final beat.
//  slv_w_last is not checked against len; the beat count rules.
//  AW and AR may be accepted in the same cycle; there is no read/write ordering.
//  Valid stays asserted until its handshake (no retraction). A mid-burst reset aborts and returns to IDLE.
//  Latency: first Lite AW/AR one cycle after slave handshake; B one cycle after last Lite B.
// STRUCTURE
//  Package axi_burst_to_lite_pkg holds:
//   resp_t (OKAY/EXOKAY/SLVERR/DECERR), burst_t, wr_state_e, rd_state_e, beat_cnt_t (8b),
//   and function resp_max().
//  Sub-module axi_burst_addr_gen (combinational next-address plus legality check), instantiated once per direction.
// TESTING
//  INCR len=3 size=2 addr=0x100, Lite B all OKAY -> Lite AW 0x100,0x104,0x108,0x10C; one B OKAY with same id.
//  WRAP len=3 size=2 addr=0x108 read -> Lite AR 0x108,0x10C,0x100,0x104; last only on 4th R.
//  FIXED len=2 addr=0x40 write, 2nd Lite B=SLVERR -> 3 AWs to 0x40; slave B=SLVERR.
//  burst=2'b11 read len=1 id=5 -> no mst_ar_valid; 2 R beats id=5 SLVERR data 0, last on 2nd.
//  Concurrent AW+AR with mst_*_ready stalled 10 cycles -> valids held stable, both complete, no deadlock.
//  rst_i pulsed mid-write burst -> all valids 0 next edge; new burst after reset completes normally.

Source files
------------

// File: rtl/axi_burst_to_lite_pkg.sv
// Shared types for the AXI4 burst to AXI4-Lite converter: response/burst encodings,
// FSM state enums, the beat counter type and the worst-case response merge.
package axi_burst_to_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_BEAT,
        WR_WRSP,
        WR_BRSP,
        WR_SINK
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_ERR
    } rd_state_e;

    typedef logic [7:0] beat_cnt_t;

    // Higher encoding is the more severe response, so a plain max merges a burst's B responses.
    function automatic resp_t resp_max(input resp_t a, input resp_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts and burst legality check.
module axi_burst_addr_gen
    import axi_burst_to_lite_pkg::*;
#(
    parameter int AxiAddrWidth = 32,
    parameter int AxiDataWidth = 32,
    parameter bit SupportWrap  = 1'b1
) (
    input  logic [AxiAddrWidth-1:0] addr,
    input  beat_cnt_t               len,
    input  logic [2:0]              size,
    input  burst_t                  burst,
    output logic [AxiAddrWidth-1:0] next_addr,
    output logic                    illegal
);

    localparam int SizeMax = $clog2(AxiDataWidth / 8);

    typedef logic [AxiAddrWidth-1:0] addr_t;

    addr_t inc;
    addr_t aligned;
    addr_t wrap_mask;
    logic  wrap_len_ok;

    always_comb begin
        inc       = addr_t'(1) << size;
        aligned   = addr & ~(inc - addr_t'(1));
        wrap_mask = ((addr_t'(len) + addr_t'(1)) * inc) - addr_t'(1);
        next_addr = aligned + inc;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((aligned + inc) & wrap_mask);
            default:     next_addr = aligned + inc;
        endcase
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        illegal     = (burst == BURST_RSVD)
                   || (int'(size) > SizeMax)
                   || ((burst == BURST_WRAP) && (!SupportWrap || !wrap_len_ok));
    end

endmodule

// File: rtl/axi_burst_to_lite_conv.sv
// AXI4 slave to AXI4-Lite master converter: splits bursts into single Lite transfers,
// reflects IDs, merges B responses worst-case and answers illegal bursts locally with SLVERR.
module axi_burst_to_lite_conv
    import axi_burst_to_lite_pkg::*;
#(
    parameter int AxiAddrWidth = 32,
    parameter int AxiDataWidth = 32,
    parameter int AxiIdWidth   = 4,
    parameter bit SupportWrap  = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AxiIdWidth-1:0]     slv_aw_id,
    input  logic [AxiAddrWidth-1:0]   slv_aw_addr,
    input  logic [7:0]                slv_aw_len,
    input  logic [2:0]                slv_aw_size,
    input  logic [1:0]                slv_aw_burst,
    input  logic                      slv_aw_valid,
    output logic                      slv_aw_ready,
    input  logic [AxiDataWidth-1:0]   slv_w_data,
    input  logic [AxiDataWidth/8-1:0] slv_w_strb,
    input  logic                      slv_w_last,
    input  logic                      slv_w_valid,
    output logic                      slv_w_ready,
    output logic [AxiIdWidth-1:0]     slv_b_id,
    output logic [1:0]                slv_b_resp,
    output logic                      slv_b_valid,
    input  logic                      slv_b_ready,
    input  logic [AxiIdWidth-1:0]     slv_ar_id,
    input  logic [AxiAddrWidth-1:0]   slv_ar_addr,
    input  logic [7:0]                slv_ar_len,
    input  logic [2:0]                slv_ar_size,
    input  logic [1:0]                slv_ar_burst,
    input  logic                      slv_ar_valid,
    output logic                      slv_ar_ready,
    output logic [AxiIdWidth-1:0]     slv_r_id,
    output logic [AxiDataWidth-1:0]   slv_r_data,
    output logic [1:0]                slv_r_resp,
    output logic                      slv_r_last,
    output logic                      slv_r_valid,
    input  logic                      slv_r_ready,
    output logic [AxiAddrWidth-1:0]   mst_aw_addr,
    output logic                      mst_aw_valid,
    input  logic                      mst_aw_ready,
    output logic [AxiDataWidth-1:0]   mst_w_data,
    output logic [AxiDataWidth/8-1:0] mst_w_strb,
    output logic                      mst_w_valid,
    input  logic                      mst_w_ready,
    input  logic [1:0]                mst_b_resp,
    input  logic                      mst_b_valid,
    output logic                      mst_b_ready,
    output logic [AxiAddrWidth-1:0]   mst_ar_addr,
    output logic                      mst_ar_valid,
    input  logic                      mst_ar_ready,
    input  logic [AxiDataWidth-1:0]   mst_r_data,
    input  logic [1:0]                mst_r_resp,
    input  logic                      mst_r_valid,
    output logic                      mst_r_ready
);

    typedef logic [AxiAddrWidth-1:0] addr_t;

    wr_state_e             wr_state;
    logic [AxiIdWidth-1:0] wr_id;
    addr_t                 wr_addr;
    beat_cnt_t             wr_len;
    beat_cnt_t             wr_beat;
    logic [2:0]            wr_size;
    burst_t                wr_burst;
    resp_t                 wr_resp;
    logic                  w_pend;
    addr_t                 wr_next;
    logic                  wr_illegal;
    logic                  wr_idle;

    rd_state_e             rd_state;
    logic [AxiIdWidth-1:0] rd_id;
    addr_t                 rd_addr;
    beat_cnt_t             rd_len;
    beat_cnt_t             rd_beat;
    logic [2:0]            rd_size;
    burst_t                rd_burst;
    addr_t                 rd_next;
    logic                  rd_illegal;
    logic                  rd_idle;

    // In IDLE the generators look at the incoming request so legality is known at the handshake.
    assign wr_idle = (wr_state == WR_IDLE);
    assign rd_idle = (rd_state == RD_IDLE);

    axi_burst_addr_gen #(
        .AxiAddrWidth(AxiAddrWidth),
        .AxiDataWidth(AxiDataWidth),
        .SupportWrap (SupportWrap)
    ) u_wr_gen (
        .addr     (wr_idle ? slv_aw_addr : wr_addr),
        .len      (wr_idle ? slv_aw_len : wr_len),
        .size     (wr_idle ? slv_aw_size : wr_size),
        .burst    (wr_idle ? burst_t'(slv_aw_burst) : wr_burst),
        .next_addr(wr_next),
        .illegal  (wr_illegal)
    );

    axi_burst_addr_gen #(
        .AxiAddrWidth(AxiAddrWidth),
        .AxiDataWidth(AxiDataWidth),
        .SupportWrap (SupportWrap)
    ) u_rd_gen (
        .addr     (rd_idle ? slv_ar_addr : rd_addr),
        .len      (rd_idle ? slv_ar_len : rd_len),
        .size     (rd_idle ? slv_ar_size : rd_size),
        .burst    (rd_idle ? burst_t'(slv_ar_burst) : rd_burst),
        .next_addr(rd_next),
        .illegal  (rd_illegal)
    );

    assign mst_aw_addr = wr_addr;
    assign mst_w_data  = slv_w_data;
    assign mst_w_strb  = slv_w_strb;
    assign mst_w_valid = (wr_state == WR_BEAT) && w_pend && slv_w_valid;
    assign slv_w_ready = (wr_state == WR_SINK) || ((wr_state == WR_BEAT) && w_pend && mst_w_ready);
    assign slv_b_id    = wr_id;
    assign slv_b_resp  = wr_resp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state     <= WR_IDLE;
            slv_aw_ready <= 1'b0;
            mst_aw_valid <= 1'b0;
            w_pend       <= 1'b0;
            mst_b_ready  <= 1'b0;
            slv_b_valid  <= 1'b0;
            wr_id        <= '0;
            wr_addr      <= '0;
            wr_len       <= '0;
            wr_size      <= '0;
            wr_burst     <= BURST_FIXED;
            wr_beat      <= '0;
            wr_resp      <= RESP_OKAY;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (slv_aw_valid && slv_aw_ready) begin
                        slv_aw_ready <= 1'b0;
                        wr_id        <= slv_aw_id;
                        wr_addr      <= slv_aw_addr;
                        wr_len       <= slv_aw_len;
                        wr_size      <= slv_aw_size;
                        wr_burst     <= burst_t'(slv_aw_burst);
                        wr_beat      <= '0;
                        wr_resp      <= RESP_OKAY;
                        if (wr_illegal) begin
                            wr_state <= WR_SINK;
                        end else begin
                            mst_aw_valid <= 1'b1;
                            w_pend       <= 1'b1;
                            wr_state     <= WR_BEAT;
                        end
                    end else begin
                        slv_aw_ready <= 1'b1;
                    end
                end
                WR_BEAT: begin
                    if (mst_aw_valid && mst_aw_ready) mst_aw_valid <= 1'b0;
                    if (mst_w_valid && mst_w_ready) w_pend <= 1'b0;
                    if ((!mst_aw_valid || mst_aw_ready) && (!w_pend || (mst_w_valid && mst_w_ready))) begin
                        mst_b_ready <= 1'b1;
                        wr_state    <= WR_WRSP;
                    end
                end
                WR_WRSP: begin
                    if (mst_b_valid) begin
                        mst_b_ready <= 1'b0;
                        wr_resp     <= resp_max(wr_resp, resp_t'(mst_b_resp));
                        if (wr_beat == wr_len) begin
                            slv_b_valid <= 1'b1;
                            wr_state    <= WR_BRSP;
                        end else begin
                            wr_beat      <= wr_beat + 8'd1;
                            wr_addr      <= wr_next;
                            mst_aw_valid <= 1'b1;
                            w_pend       <= 1'b1;
                            wr_state     <= WR_BEAT;
                        end
                    end
                end
                // Illegal burst: swallow its write data, then answer SLVERR.
                WR_SINK: begin
                    if (slv_w_valid && slv_w_last) begin
                        wr_resp     <= RESP_SLVERR;
                        slv_b_valid <= 1'b1;
                        wr_state    <= WR_BRSP;
                    end
                end
                WR_BRSP: begin
                    if (slv_b_ready) begin
                        slv_b_valid  <= 1'b0;
                        slv_aw_ready <= 1'b1;
                        wr_state     <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    assign mst_ar_addr = rd_addr;
    assign mst_r_ready = (rd_state == RD_DATA) && slv_r_ready;
    assign slv_r_valid = ((rd_state == RD_DATA) && mst_r_valid) || (rd_state == RD_ERR);
    assign slv_r_data  = (rd_state == RD_DATA) ? mst_r_data : '0;
    assign slv_r_resp  = (rd_state == RD_DATA) ? mst_r_resp : 2'(RESP_SLVERR);
    assign slv_r_last  = ((rd_state == RD_DATA) || (rd_state == RD_ERR)) && (rd_beat == rd_len);
    assign slv_r_id    = rd_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state     <= RD_IDLE;
            slv_ar_ready <= 1'b0;
            mst_ar_valid <= 1'b0;
            rd_id        <= '0;
            rd_addr      <= '0;
            rd_len       <= '0;
            rd_size      <= '0;
            rd_burst     <= BURST_FIXED;
            rd_beat      <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (slv_ar_valid && slv_ar_ready) begin
                        slv_ar_ready <= 1'b0;
                        rd_id        <= slv_ar_id;
                        rd_addr      <= slv_ar_addr;
                        rd_len       <= slv_ar_len;
                        rd_size      <= slv_ar_size;
                        rd_burst     <= burst_t'(slv_ar_burst);
                        rd_beat      <= '0;
                        if (rd_illegal) begin
                            rd_state <= RD_ERR;
                        end else begin
                            mst_ar_valid <= 1'b1;
                            rd_state     <= RD_ADDR;
                        end
                    end else begin
                        slv_ar_ready <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (mst_ar_ready) begin
                        mst_ar_valid <= 1'b0;
                        rd_state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (mst_r_valid && slv_r_ready) begin
                        if (rd_beat == rd_len) begin
                            slv_ar_ready <= 1'b1;
                            rd_state     <= RD_IDLE;
                        end else begin
                            rd_beat      <= rd_beat + 8'd1;
                            rd_addr      <= rd_next;
                            mst_ar_valid <= 1'b1;
                            rd_state     <= RD_ADDR;
                        end
                    end
                end
                RD_ERR: begin
                    if (slv_r_ready) begin
                        if (rd_beat == rd_len) begin
                            slv_ar_ready <= 1'b1;
                            rd_state     <= RD_IDLE;
                        end else begin
                            rd_beat <= rd_beat + 8'd1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule
